// File: rtl/ml_pkg.sv
// Shared types and SM2 constants for the Montgomery-ladder sequencer and its bench.
package ml_pkg;

  typedef enum logic [1:0] {
    OP_INIT_PG = 2'd0,
    OP_INIT_OP = 2'd1,
    OP_LADDER  = 2'd2
  } step_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int NUM_ELEMENTS = 17;
  localparam int BIT_LEN      = 17;
  localparam int WORD_LEN     = 16;

  localparam logic [255:0] SM2_P  =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [255:0] SM2_GX =
    256'h32C4AE2C_1F198119_5F990446_6A39C994_8FE30BBF_F2660BE1_715A4589_334C74C7;
  localparam logic [255:0] SM2_GY =
    256'hBC3736A2_F4F6779C_59BDCEE3_6B692153_D0A9877C_C62A4740_02DF32E5_2139F0A0;

endpackage

// File: rtl/ml_lod.sv
// Leading-one detector: index of the highest set bit, plus an all-zero flag.
module ml_lod #(
  parameter int DATA_LEN = 256,
  parameter int IDX_W    = $clog2(DATA_LEN)
) (
  input  logic [DATA_LEN-1:0] vec,
  output logic [IDX_W-1:0]    msb,
  output logic                zero
);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    msb  = '0;
    zero = 1'b1;
    for (int i = 0; i < DATA_LEN; i++) begin
      if (vec[i]) begin
        msb  = IDX_W'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ml_ladder_seq.sv
// Montgomery-ladder sequencer: scans a latched scalar MSB-first and issues one
// init or ladder-step request per bit to the PAD engine over req/ack.
module ml_ladder_seq
  import ml_pkg::*;
#(
  parameter int DATA_LEN = 256,
  parameter int IDX_W    = $clog2(DATA_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                const_time,
  input  logic [DATA_LEN-1:0] k,
  output logic                busy,
  output logic                done,
  output logic                zero_k,
  output logic                step_req,
  output logic [1:0]          step_op,
  output logic                step_bit,
  output logic [IDX_W-1:0]    step_idx,
  input  logic                step_ack,
  output logic [IDX_W:0]      step_cnt
);

  state_t              state;
  logic [DATA_LEN-1:0] k_reg;
  logic                ct_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic                ladder_left;
  logic                init_pend;
  step_op_t            init_op;
  logic [IDX_W-1:0]    lod_msb;
  logic                lod_zero;

  ml_lod #(.DATA_LEN(DATA_LEN), .IDX_W(IDX_W)) u_lod (
    .vec  (k_reg),
    .msb  (lod_msb),
    .zero (lod_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      k_reg       <= '0;
      ct_reg      <= 1'b0;
      idx_reg     <= '0;
      ladder_left <= 1'b0;
      init_pend   <= 1'b0;
      init_op     <= OP_INIT_PG;
      busy        <= 1'b0;
      done        <= 1'b0;
      zero_k      <= 1'b0;
      step_req    <= 1'b0;
      step_op     <= 2'd0;
      step_bit    <= 1'b0;
      step_idx    <= '0;
      step_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            k_reg    <= k;
            ct_reg   <= const_time;
            step_cnt <= '0;
            zero_k   <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (lod_zero) begin
            zero_k <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_DONE;
          end else begin
            init_pend <= 1'b1;
            init_op   <= ct_reg ? OP_INIT_OP : OP_INIT_PG;
            // Skip mode: the MSB itself is absorbed by INIT_PG (R0=P).
            idx_reg     <= ct_reg ? IDX_W'(DATA_LEN - 1) : lod_msb - 1'b1;
            ladder_left <= ct_reg | (lod_msb != '0);
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          step_req <= 1'b1;
          if (init_pend) begin
            step_op  <= init_op;
            step_bit <= 1'b0;
            step_idx <= '0;
          end else begin
            step_op  <= OP_LADDER;
            step_bit <= k_reg[idx_reg];
            step_idx <= idx_reg;
          end
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (step_ack) begin
            step_req <= 1'b0;
            step_cnt <= step_cnt + 1'b1;
            if (init_pend) begin
              init_pend <= 1'b0;
              if (ladder_left) begin
                state <= ST_ISSUE;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_DONE;
              end
            end else if (idx_reg == '0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              idx_reg <= idx_reg - 1'b1;
              state   <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ml_ladder_seq.sv
// Directed bench for ml_ladder_seq: behavioural PAD engine responder and op recorder.
module tb_ml_ladder_seq;
  import ml_pkg::*;

  localparam int DL = 256;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          const_time = 1'b0;
  logic [DL-1:0] k = '0;
  logic          busy, done, zero_k, step_req, step_bit, step_ack;
  logic [1:0]    step_op;
  logic [IW-1:0] step_idx;
  logic [IW:0]   step_cnt;

  ml_ladder_seq #(.DATA_LEN(DL), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .const_time(const_time), .k(k),
    .busy(busy), .done(done), .zero_k(zero_k), .step_req(step_req),
    .step_op(step_op), .step_bit(step_bit), .step_idx(step_idx),
    .step_ack(step_ack), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Recorded ops of the latest run and the reference sequence.
  logic [1:0]    rec_op [0:299];
  logic [IW-1:0] rec_idx[0:299];
  logic          rec_bit[0:299];
  logic [1:0]    exp_op [0:299];
  logic [IW-1:0] exp_idx[0:299];
  logic          exp_bit[0:299];
  int nrec, nexp, done_cnt, done_cycle, first_req, busy_cycles, stable_bad;
  logic zk_seen;
  bit aborted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: ops a Montgomery ladder needs for scalar kv in the given mode.
  task automatic build_exp(input logic [DL-1:0] kv, input logic ct);
    int msb;
    nexp = 0;
    msb  = -1;
    for (int i = DL - 1; i >= 0; i--) if (kv[i] && msb < 0) msb = i;
    if (msb < 0) return;
    exp_op[0] = ct ? 2'd1 : 2'd0; exp_idx[0] = '0; exp_bit[0] = 1'b0;
    nexp = 1;
    for (int i = (ct ? DL - 1 : msb - 1); i >= 0; i--) begin
      exp_op[nexp] = 2'd2; exp_idx[nexp] = IW'(i); exp_bit[nexp] = kv[i];
      nexp++;
    end
  endtask

  task automatic compare_seq(input string tag);
    int mism;
    mism = 0;
    check({tag, "_nops"}, nrec, nexp);
    for (int i = 0; i < nrec && i < nexp; i++)
      if (rec_op[i] !== exp_op[i] || rec_idx[i] !== exp_idx[i] || rec_bit[i] !== exp_bit[i])
        mism++;
    check({tag, "_seq_mismatches"}, mism, 0);
  endtask

  // One run: pulse start, then act as the engine until done (or abort on reset).
  task automatic run(input logic [DL-1:0] kv, input logic ct, input int dly,
                     input int stall_idx, input bit spur, input bit midstart,
                     input int rst_idx);
    int n, wcnt;
    bit prev_req, fin;
    nrec = 0; done_cnt = 0; done_cycle = -1; first_req = -1;
    busy_cycles = 0; stable_bad = 0; aborted = 0; zk_seen = 1'b0;
    @(negedge clk); start = 1'b1; k = kv; const_time = ct;
    @(negedge clk);
    n = 1; prev_req = 0; wcnt = 0; fin = 0;
    while (!fin && n < 3000) begin
      step_ack = 1'b0;
      start    = 1'b0;
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++; done_cycle = n; zk_seen = zero_k; fin = 1;
      end else if (step_req) begin
        if (!prev_req) begin
          rec_op[nrec] = step_op; rec_idx[nrec] = step_idx; rec_bit[nrec] = step_bit;
          nrec++; wcnt = 0;
          if (first_req < 0) first_req = n;
        end else if (step_op !== rec_op[nrec-1] || step_idx !== rec_idx[nrec-1] ||
                     step_bit !== rec_bit[nrec-1]) begin
          stable_bad++;
        end
        wcnt++;
        if (rst_idx >= 0 && step_op == 2'd2 && step_idx == IW'(rst_idx)) begin
          rst = 1'b1; aborted = 1; fin = 1;
        end else if (wcnt >= ((step_op == 2'd2 && step_idx == IW'(stall_idx)) ? 10 : dly)) begin
          step_ack = 1'b1;
        end
      end else if (spur && busy && n >= 2) begin
        step_ack = 1'b1;
      end
      if (midstart && n == 12) begin
        start = 1'b1; k = DL'(7);
      end
      prev_req = step_req;
      if (!fin) begin
        @(negedge clk);
        n++;
      end
    end
    if (!fin) check("run_timeout", 1, 0);
  endtask

  initial begin
    step_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, zero_k, step_req, step_op, step_bit, step_idx, step_cnt}, 0);
    rst = 1'b0;

    // k=20 skip mode: INIT_PG, (3,0) (2,1) (1,0) (0,0).
    run(DL'(20), 1'b0, 3, -1, 0, 0, -1);
    check("k20s_first_req_cycle", first_req, 3);
    check("k20s_nops", nrec, 5);
    check("k20s_op0", rec_op[0], 0);
    check("k20s_op1", {rec_op[1], rec_idx[1], rec_bit[1]}, {2'd2, 8'd3, 1'b0});
    check("k20s_op2", {rec_op[2], rec_idx[2], rec_bit[2]}, {2'd2, 8'd2, 1'b1});
    check("k20s_op3", {rec_op[3], rec_idx[3], rec_bit[3]}, {2'd2, 8'd1, 1'b0});
    check("k20s_op4", {rec_op[4], rec_idx[4], rec_bit[4]}, {2'd2, 8'd0, 1'b0});
    check("k20s_step_cnt", step_cnt, 5);
    check("k20s_zero_k", zk_seen, 0);
    check("k20s_busy_at_done", busy, 0);
    @(negedge clk);
    check("k20s_done_one_pulse", done, 0);
    $display("txn k=20 ct=0 ops=%0d cnt=%0d", nrec, step_cnt);

    // Spurious ack while idle must not count.
    @(negedge clk); step_ack = 1'b1;
    @(negedge clk); step_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_ignored", step_cnt, 5);
    $display("txn idle spurious ack cnt=%0d", step_cnt);

    // k=20 constant time: INIT_OP then 256 ladder ops.
    run(DL'(20), 1'b1, 3, -1, 0, 0, -1);
    build_exp(DL'(20), 1'b1);
    compare_seq("k20c");
    check("k20c_op0", rec_op[0], 1);
    check("k20c_first_ladder_idx", rec_idx[1], 255);
    check("k20c_last_ladder_idx", rec_idx[256], 0);
    check("k20c_bit_idx4", rec_bit[256-4], 1);
    check("k20c_bit_idx2", rec_bit[256-2], 1);
    check("k20c_step_cnt", step_cnt, 257);
    $display("txn k=20 ct=1 ops=%0d cnt=%0d", nrec, step_cnt);

    // k=0 both modes: no requests, done at cycle 2, busy for one cycle.
    for (int m = 0; m < 2; m++) begin
      run(DL'(0), m[0], 3, -1, 0, 0, -1);
      check("k0_nops", nrec, 0);
      check("k0_done_cycle", done_cycle, 2);
      check("k0_zero_k", zk_seen, 1);
      check("k0_busy_cycles", busy_cycles, 1);
      check("k0_step_cnt", step_cnt, 0);
      @(negedge clk);
      check("k0_zero_k_held", zero_k, 1);
      $display("txn k=0 ct=%0d done_cycle=%0d zero_k=%0d", m, done_cycle, zk_seen);
    end

    // k=1 skip mode: single INIT_PG.
    run(DL'(1), 1'b0, 2, -1, 0, 0, -1);
    check("k1_nops", nrec, 1);
    check("k1_op0", rec_op[0], 0);
    check("k1_step_cnt", step_cnt, 1);
    check("k1_zero_k", zk_seen, 0);
    $display("txn k=1 ct=0 ops=%0d cnt=%0d", nrec, step_cnt);

    // k=2^255 skip mode: INIT_PG then idx 254..0.
    begin
      logic [DL-1:0] kt;
      kt = '0; kt[DL-1] = 1'b1;
      run(kt, 1'b0, 1, -1, 0, 0, -1);
      build_exp(kt, 1'b0);
      compare_seq("k2p255");
      check("k2p255_first_idx", rec_idx[1], 254);
      check("k2p255_step_cnt", step_cnt, 256);
      $display("txn k=2^255 ct=0 ops=%0d cnt=%0d", nrec, step_cnt);
    end

    // Robustness: spurious acks in ISSUE, mid-run start with k=7, 10-cycle stall at idx 2.
    run(DL'(20), 1'b0, 3, 2, 1, 1, -1);
    build_exp(DL'(20), 1'b0);
    compare_seq("robust");
    check("robust_stable", stable_bad, 0);
    check("robust_step_cnt", step_cnt, 5);
    check("robust_done_cnt", done_cnt, 1);
    $display("txn robust k=20 ops=%0d cnt=%0d", nrec, step_cnt);

    // Reset during WAIT at ladder idx 2, then recover with k=3.
    run(DL'(20), 1'b0, 3, -1, 0, 0, 2);
    check("rst_aborted", aborted, 1);
    @(negedge clk);
    check("rst_mid_outputs", {busy, done, zero_k, step_req, step_op, step_bit, step_idx, step_cnt}, 0);
    rst = 1'b0;
    run(DL'(3), 1'b0, 3, -1, 0, 0, -1);
    check("k3_nops", nrec, 2);
    check("k3_op0", rec_op[0], 0);
    check("k3_op1", {rec_op[1], rec_idx[1], rec_bit[1]}, {2'd2, 8'd0, 1'b1});
    check("k3_done_cnt", done_cnt, 1);
    check("k3_step_cnt", step_cnt, 2);
    $display("txn rst-recover k=3 ops=%0d cnt=%0d", nrec, step_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ml_ladder_seq.md
Name: ml_ladder_seq

Overview:
- Montgomery-ladder scalar-multiplication sequencer for the SM2 point add-double engine.
- Latches a scalar k of DATA_LEN bits and scans it MSB-first. For each bit it issues one init or ladder-step request to the external PAD step datapath over a req/ack handshake.
- Generalises the single fixed-width FSM in two ways: the scalar width is parametrised, and it has two run-time modes. One mode skips leading zeros for speed; the other runs every bit for constant time.
- Sits between the top-level point-multiply controller and the redundant-form PAD datapath.

Parameters:
- DATA_LEN, 256, scalar width in bits (>=2).
- IDX_W, $clog2(DATA_LEN), width of bit-index signals.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new scalar multiplication; sampled only in IDLE.
- const_time  in  1  mode, latched with start: 1 = process all DATA_LEN bits; 0 = skip leading zeros.
- k  in  DATA_LEN  scalar, latched with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- zero_k  out  1  valid with done: the latched k was 0, the result is the point at infinity, and no engine ops were issued.
- step_req  out  1  request to the PAD engine; held until step_ack.
- step_op  out  2  0 = OP_INIT_PG (R0=P, R1=2P); 1 = OP_INIT_OP (R0=O, R1=P); 2 = OP_LADDER.
- step_bit  out  1  scalar bit for OP_LADDER (swap select); 0 for init ops.
- step_idx  out  IDX_W  index of step_bit; 0 for init ops.
- step_ack  in  1  engine completion pulse for the outstanding request.
- step_cnt  out  IDX_W+1  number of acks received this run.

Behaviour:
- Reset values: all outputs 0; state IDLE; latched k and mode cleared.
- States: IDLE, SCAN, ISSUE, WAIT, DONE.
- IDLE: when start=1, latch k and const_time, clear step_cnt, then go to SCAN. Otherwise stay.
- SCAN (one cycle): ml_lod computes msb, the index of the highest set bit of the latched k.
  - k==0: go to DONE with zero_k=1.
  - const_time=1: first op is OP_INIT_OP; next ladder index is DATA_LEN-1.
  - const_time=0: first op is OP_INIT_PG; next ladder index is msb-1. If msb==0 there are no ladder steps.
- ISSUE (one cycle, step_req=0): drive step_op/step_bit/step_idx for the next op, then go to WAIT.
- WAIT: step_req=1 and the op outputs are held stable until step_ack.
  - On step_ack: step_cnt increments.
  - If ladder steps remain: the index decrements and the state goes to ISSUE.
  - After the op at index 0, or after an init with no ladder steps: go to DONE.
- DONE (one cycle): done=1, zero_k as computed, busy=0, then go to IDLE. The zero_k value holds until the next start.
- Request count per run: const mode = 1 + DATA_LEN; skip mode = 1 + msb; k==0 → 0.
- Latency: start sampled at edge 0 → SCAN at cycle 1 → first step_req high at cycle 3. Each op adds ack latency + 1 idle cycle. k==0: done at cycle 2.
- busy is high in SCAN, ISSUE and WAIT.
- step_ack outside WAIT is ignored.
- start while not IDLE is ignored, with no effect on latched k.
- Index wrap: the decrement from index 0 never occurs; the exit is decided on ack of index 0.
- rst mid-run: the next cycle is IDLE with all outputs 0. Any outstanding engine request is abandoned; the engine is reset by the same rst.
- step_bit is latched k[step_idx], registered.

Decomposition:
- Package ml_pkg:
  - step_op enum (OP_INIT_PG, OP_INIT_OP, OP_LADDER);
  - state enum;
  - SM2 constants shared with the bench (prime p, base point Gx/Gy, NUM_ELEMENTS=17, BIT_LEN=17, WORD_LEN=16).
- Sub-module ml_lod: parametrised leading-one detector over DATA_LEN. Combinational outputs are msb (IDX_W) and zero (1). It is registered into SCAN results by the sequencer.

Test Plan:
- k=20 (10100b), const_time=0, engine acks 3 cycles after req → ops INIT_PG then LADDER (idx,bit) = (3,0), (2,1), (1,0), (0,0); step_cnt=5; one done pulse; zero_k=0.
- k=20, const_time=1 → INIT_OP then 256 LADDER ops, idx 255..0; bits match k (only idx 4 and 2 carry bit=1); step_cnt=257.
- k=0, either mode → no step_req ever; done at cycle 2 after start; zero_k=1; busy high exactly 1 cycle.
- k=1, const_time=0 → single INIT_PG, no ladder ops, step_cnt=1. k=2^255, const_time=0 → INIT_PG then 255 LADDER ops; only idx 255 absent.
- Handshake robustness on a k=20 skip-mode run:
  - spurious step_ack in ISSUE and IDLE is ignored;
  - start pulsed mid-run with k=7 does not alter the sequence;
  - step_op/step_idx stay stable across a 10-cycle ack stall.
- rst asserted during WAIT at step idx 2 → next cycle all outputs 0; a subsequent start with k=3, const_time=0 yields INIT_PG, LADDER(0,1) and a correct done.
